// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//   Word-addressed data memory for the CPU datapath. One synchronous write
//   port and one synchronous, independently addressed read port. Storage is
//   built from flops so the asynchronous reset can clear every word.
//
// Parameters:
//   N  address width in bits (depth = 2^N words)
//   B  byte width in bits (word width = 4*B)
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset (clears r_data and all words)
//   r_addr  in   N    read word address
//   w_addr  in   N    write word address
//   w_en    in   1    write enable
//   r_en    in   1    read enable
//   w_data  in   4*B  write data
//   r_data  out  4*B  registered read data (1-cycle latency, holds when r_en=0)
//
// Configuration:
//   DMEM_WR_BYPASS_EN  defined   -> write-first on a same-address collision
//                      undefined -> read-first (old contents returned)
// -----------------------------------------------------------------------------
module data_memory #(
    parameter int N = 8,
    parameter int B = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     r_addr,
    input  logic [N-1:0]     w_addr,
    input  logic             w_en,
    input  logic             r_en,
    input  logic [4*B-1:0]   w_data,
    output logic [4*B-1:0]   r_data
);

    localparam int W     = 4 * B;
    localparam int DEPTH = 1 << N;

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] w_rd_word;

    // Select the word to load into r_data on the next edge.
    always_comb begin
        w_rd_word = r_mem[r_addr];
`ifdef DMEM_WR_BYPASS_EN
        // Same-edge collision forwards the incoming write data.
        if (w_en && (r_addr == w_addr)) begin
            w_rd_word = w_data;
        end else begin
            w_rd_word = r_mem[r_addr];
        end
`endif
    end

    // Storage array: cleared by reset, written on enabled edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_en) begin
            r_mem[w_addr] <= w_data;
        end else begin
            r_mem[w_addr] <= r_mem[w_addr];
        end
    end

    // Registered read port; holds its value while r_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (r_en) begin
            r_data <= w_rd_word;
        end else begin
            r_data <= r_data;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
//   Self-checking bench for data_memory (N=8, B=8). Directed scenarios cover
//   reset, write/read, hold, collision, address boundaries and reset during a
//   pending write; a randomized phase is checked against an array model.
// -----------------------------------------------------------------------------
module tb_data_memory;

    localparam int N = 8;
    localparam int B = 8;
    localparam int DEPTH = 256;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  r_addr;
    logic [N-1:0]  w_addr;
    logic          w_en;
    logic          r_en;
    logic [31:0]   w_data;
    logic [31:0]   r_data;

    int n_checks;
    int n_errors;

    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] mdl_rd;

    data_memory #(.N(N), .B(B)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .r_addr (r_addr),
        .w_addr (w_addr),
        .w_en   (w_en),
        .r_en   (r_en),
        .w_data (w_data),
        .r_data (r_data)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'd0;
        mdl_rd = 32'd0;
    endtask

    // One clock cycle: drive at negedge, update model at posedge, check after.
    task automatic cycle(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                         input logic re, input logic [7:0] ra, input string tag);
        @(negedge clk);
        w_en = we; w_addr = wa; w_data = wd; r_en = re; r_addr = ra;
        @(posedge clk);
        if (re) begin
`ifdef DMEM_WR_BYPASS_EN
            mdl_rd = (we && (wa == ra)) ? wd : mdl_mem[ra];
`else
            mdl_rd = mdl_mem[ra];
`endif
        end
        if (we) mdl_mem[wa] = wd;
        #1;
        check(tag, r_data, mdl_rd);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n  = 1'b0;
        w_en   = 1'b0;
        r_en   = 1'b0;
        w_addr = 8'd0;
        r_addr = 8'd0;
        w_data = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", r_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Read of address 3 after reset returns 0.
        cycle(1'b0, 8'd0, 32'd0, 1'b1, 8'd3, "rst_read3");

        // Write then read.
        cycle(1'b1, 8'd3, 32'd25, 1'b0, 8'd3, "wr3_no_read");
        check("before_ren", r_data, 32'd0);
        cycle(1'b0, 8'd0, 32'd0, 1'b1, 8'd3, "read3");
        check("read3_val", r_data, 32'd25);

        // Hold while r_en is low, then pick up new value.
        cycle(1'b1, 8'd3, 32'd99, 1'b0, 8'd3, "hold_wr99");
        cycle(1'b0, 8'd0, 32'd0, 1'b0, 8'd3, "hold_idle");
        check("hold_val", r_data, 32'd25);
        cycle(1'b0, 8'd0, 32'd0, 1'b1, 8'd3, "read99");
        check("read99_val", r_data, 32'd99);

        // Same-address collision.
        cycle(1'b1, 8'd5, 32'd7, 1'b0, 8'd0, "coll_setup");
        cycle(1'b1, 8'd5, 32'd11, 1'b1, 8'd5, "coll");
`ifdef DMEM_WR_BYPASS_EN
        check("coll_val", r_data, 32'd11);
`else
        check("coll_val", r_data, 32'd7);
`endif
        cycle(1'b0, 8'd0, 32'd0, 1'b1, 8'd5, "coll_next");
        check("coll_next_val", r_data, 32'd11);

        // Different-address read and write on the same edge.
        cycle(1'b1, 8'd6, 32'h1234_5678, 1'b1, 8'd3, "diff_addr");
        check("diff_addr_val", r_data, 32'd99);

        // Address boundaries.
        cycle(1'b1, 8'd255, 32'hFFFF_FFFF, 1'b0, 8'd0, "wr255");
        cycle(1'b1, 8'd0, 32'h0000_0001, 1'b0, 8'd0, "wr0");
        cycle(1'b0, 8'd0, 32'd0, 1'b1, 8'd255, "rd255");
        check("rd255_val", r_data, 32'hFFFF_FFFF);
        cycle(1'b0, 8'd0, 32'd0, 1'b1, 8'd0, "rd0");
        check("rd0_val", r_data, 32'h0000_0001);
        cycle(1'b0, 8'd0, 32'd0, 1'b1, 8'd254, "rd254");
        check("rd254_val", r_data, 32'd0);
        cycle(1'b0, 8'd0, 32'd0, 1'b1, 8'd1, "rd1");
        check("rd1_val", r_data, 32'd0);

        // Reset mid-operation with a pending write of 25 to address 3.
        cycle(1'b0, 8'd0, 32'd0, 1'b1, 8'd255, "pre_rst");
        @(negedge clk);
        w_en = 1'b1; w_addr = 8'd3; w_data = 32'd25; r_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rdata", r_data, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_held_rdata", r_data, 32'd0);
        @(negedge clk);
        w_en = 1'b0;
        rst_n = 1'b1;
        cycle(1'b0, 8'd0, 32'd0, 1'b1, 8'd3, "post_rst_rd3");
        check("post_rst_rd3_val", r_data, 32'd0);
        cycle(1'b0, 8'd0, 32'd0, 1'b1, 8'd255, "post_rst_rd255");
        check("post_rst_rd255_val", r_data, 32'd0);

        // Randomized traffic; narrow address window forces collisions.
        for (int k = 0; k < 600; k++) begin
            logic [7:0]  wa, ra;
            logic        we, re;
            logic [31:0] wd;
            if ((k % 4) == 0) begin
                wa = 8'($urandom_range(255, 0));
                ra = 8'($urandom_range(255, 0));
            end else begin
                wa = 8'($urandom_range(7, 0));
                ra = 8'($urandom_range(7, 0));
            end
            we = 1'($urandom_range(1, 0));
            re = 1'($urandom_range(1, 0));
            wd = $urandom;
            cycle(we, wa, wd, re, ra, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
